// File: rtl/pla_pkg.sv
// Shared types and default sizes for the programmable PLA engine.
package pla_pkg;
    localparam int DEF_N_IN    = 8;
    localparam int DEF_N_OUT   = 63;
    localparam int DEF_N_TERMS = 32;

    typedef enum logic [1:0] {
        CFG_WRITE = 2'd0,
        CFG_CLEAR = 2'd1,
        CFG_PHASE = 2'd2
    } cfg_op_e;

    // Term record at the default sizes; the engine re-declares it with its own parameters.
    typedef struct packed {
        logic [DEF_N_IN-1:0]  care;
        logic [DEF_N_IN-1:0]  val;
        logic [DEF_N_OUT-1:0] or_row;
        logic                 en;
    } term_t;
endpackage

// File: rtl/pla_engine_if.sv
// Configuration, input-vector and result handshakes of the PLA engine.
interface pla_engine_if
    import pla_pkg::*;
#(
    parameter int N_IN    = DEF_N_IN,
    parameter int N_OUT   = DEF_N_OUT,
    parameter int N_TERMS = DEF_N_TERMS
);
    localparam int TW = $clog2(N_TERMS);

    logic             cfg_valid;
    logic             cfg_ready;
    cfg_op_e          cfg_op;
    logic [TW-1:0]    cfg_term;
    logic [N_IN-1:0]  cfg_care;
    logic [N_IN-1:0]  cfg_val;
    logic [N_OUT-1:0] cfg_or;
    logic             cfg_err;
    logic             in_valid;
    logic             in_ready;
    logic [N_IN-1:0]  in_data;
    logic             out_valid;
    logic             out_ready;
    logic [N_OUT-1:0] out_data;

    modport master (
        output cfg_valid, cfg_op, cfg_term, cfg_care, cfg_val, cfg_or,
        output in_valid, in_data, out_ready,
        input  cfg_ready, cfg_err, in_ready, out_valid, out_data
    );

    modport slave (
        input  cfg_valid, cfg_op, cfg_term, cfg_care, cfg_val, cfg_or,
        input  in_valid, in_data, out_ready,
        output cfg_ready, cfg_err, in_ready, out_valid, out_data
    );
endinterface

// File: rtl/pla_and_plane.sv
// Combinational AND plane: one hit bit per enabled cube that covers the input vector.
module pla_and_plane
    import pla_pkg::*;
#(
    parameter int N_IN    = DEF_N_IN,
    parameter int N_TERMS = DEF_N_TERMS
) (
    input  logic [N_IN-1:0]               in_data,
    input  logic [N_TERMS-1:0][N_IN-1:0]  care,
    input  logic [N_TERMS-1:0][N_IN-1:0]  val,
    input  logic [N_TERMS-1:0]            en,
    output logic [N_TERMS-1:0]            hit
);
    for (genvar gi = 0; gi < N_TERMS; gi++) begin : g_cube
        // A literal is satisfied when it is absent or the input bit equals its polarity.
        assign hit[gi] = en[gi] && (&(~(in_data ^ val[gi]) | ~care[gi]));
    end
endmodule

// File: rtl/pla_engine.sv
// Run-time programmable two-level PLA: flop-based term table, drain-before-config FSM,
// and a two-stage valid/ready pipeline (hit vector, then phased OR plane).
module pla_engine
    import pla_pkg::*;
#(
    parameter int N_IN    = DEF_N_IN,
    parameter int N_OUT   = DEF_N_OUT,
    parameter int N_TERMS = DEF_N_TERMS
) (
    input  logic        clk,
    input  logic        rst_n,
    pla_engine_if.slave bus
);
    localparam int TW = $clog2(N_TERMS);
    localparam logic [TW:0] TERM_LIMIT = (TW+1)'(N_TERMS);

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_CFG} state_e;

    typedef struct packed {
        logic [N_IN-1:0]  care;
        logic [N_IN-1:0]  val;
        logic [N_OUT-1:0] or_row;
        logic             en;
    } term_rec_t;

    state_e state_reg, state_next;
    logic [N_OUT-1:0]   phase_reg;
    logic               cfg_err_reg;
    logic               s1_valid_reg;
    logic [N_TERMS-1:0] s1_hit_reg;
    logic               s2_valid_reg;
    logic [N_OUT-1:0]   s2_data_reg;

    logic [N_TERMS-1:0][N_IN-1:0]  care_flat;
    logic [N_TERMS-1:0][N_IN-1:0]  val_flat;
    logic [N_TERMS-1:0][N_OUT-1:0] or_flat;
    logic [N_TERMS-1:0]            en_flat;
    logic [N_TERMS-1:0]            hit_next;
    logic [N_OUT-1:0]              or_next;
    logic s2_free, s1_free, in_fire, cfg_fire, cfg_bad;

    assign s2_free  = !s2_valid_reg || bus.out_ready;
    assign s1_free  = !s1_valid_reg || s2_free;
    assign in_fire  = bus.in_valid && bus.in_ready;
    assign cfg_fire = bus.cfg_valid && bus.cfg_ready;
    assign cfg_bad  = (bus.cfg_op == CFG_WRITE) && ({1'b0, bus.cfg_term} >= TERM_LIMIT);

    // A pending configuration closes the input door immediately so the table never
    // changes under a vector that has already been accepted.
    assign bus.in_ready  = (state_reg == ST_RUN) && !bus.cfg_valid && s1_free;
    assign bus.out_valid = s2_valid_reg;
    assign bus.out_data  = s2_data_reg;
    assign bus.cfg_err   = cfg_err_reg;

    always_comb begin
        state_next    = state_reg;
        bus.cfg_ready = 1'b0;
        unique case (state_reg)
            ST_RUN: begin
                if (bus.cfg_valid) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!bus.cfg_valid)                     state_next = ST_RUN;
                else if (!s1_valid_reg && !s2_valid_reg) state_next = ST_CFG;
            end
            ST_CFG: begin
                bus.cfg_ready = 1'b1;
                state_next    = ST_RUN;
            end
            default: state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_RUN;
            phase_reg   <= '0;
            cfg_err_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cfg_err_reg <= cfg_fire && cfg_bad;
            if (cfg_fire && bus.cfg_op == CFG_PHASE) phase_reg <= bus.cfg_or;
        end
    end

    for (genvar gi = 0; gi < N_TERMS; gi++) begin : g_term
        term_rec_t term_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                term_reg <= '0;
            end else if (cfg_fire) begin
                if (bus.cfg_op == CFG_CLEAR) begin
                    term_reg.en <= 1'b0;
                end else if (bus.cfg_op == CFG_WRITE && bus.cfg_term == TW'(gi)) begin
                    term_reg.care   <= bus.cfg_care;
                    term_reg.val    <= bus.cfg_val;
                    term_reg.or_row <= bus.cfg_or;
                    term_reg.en     <= 1'b1;
                end
            end
        end

        assign care_flat[gi] = term_reg.care;
        assign val_flat[gi]  = term_reg.val;
        assign or_flat[gi]   = term_reg.or_row;
        assign en_flat[gi]   = term_reg.en;
    end

    pla_and_plane #(
        .N_IN    (N_IN),
        .N_TERMS (N_TERMS)
    ) u_and_plane (
        .in_data (bus.in_data),
        .care    (care_flat),
        .val     (val_flat),
        .en      (en_flat),
        .hit     (hit_next)
    );

    always_comb begin
        or_next = '0;
        for (int t = 0; t < N_TERMS; t++) begin
            if (s1_hit_reg[t]) or_next = or_next | or_flat[t];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_hit_reg   <= '0;
            s2_valid_reg <= 1'b0;
            s2_data_reg  <= '0;
        end else begin
            if (s1_free) begin
                s1_valid_reg <= in_fire;
                if (in_fire) s1_hit_reg <= hit_next;
            end
            if (s2_free) begin
                s2_valid_reg <= s1_valid_reg;
                if (s1_valid_reg) s2_data_reg <= or_next ^ phase_reg;
            end
        end
    end
endmodule

// File: tb/tb_pla_engine.sv
// Self-checking bench for pla_engine: cover-level reference model, per-cycle monitor,
// directed scenarios and randomized streaming with backpressure.
module tb_pla_engine;
    import pla_pkg::*;

    localparam int N_IN    = 8;
    localparam int N_OUT   = 63;
    localparam int N_TERMS = 24;
    localparam int TW      = $clog2(N_TERMS);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pla_engine_if #(.N_IN(N_IN), .N_OUT(N_OUT), .N_TERMS(N_TERMS)) bus ();

    pla_engine #(.N_IN(N_IN), .N_OUT(N_OUT), .N_TERMS(N_TERMS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    // Reference cover: the table as the master believes it to be.
    logic [N_IN-1:0]  care_m [N_TERMS];
    logic [N_IN-1:0]  val_m  [N_TERMS];
    logic [N_OUT-1:0] or_m   [N_TERMS];
    bit               en_m   [N_TERMS];
    logic [N_OUT-1:0] phase_m;
    logic [N_OUT-1:0] exp_q [$];
    bit               err_pend;
    bit               stall_prev;
    logic [N_OUT-1:0] held;
    int               cfg_pulses = 0;
    int               out_count  = 0;

    function automatic logic [N_OUT-1:0] model_z(input logic [N_IN-1:0] x);
        logic [N_OUT-1:0] acc = '0;
        for (int t = 0; t < N_TERMS; t++)
            if (en_m[t] && ((x & care_m[t]) == (val_m[t] & care_m[t]))) acc |= or_m[t];
        return acc ^ phase_m;
    endfunction

    task automatic check(input string name, input logic [N_OUT-1:0] act, input logic [N_OUT-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            for (int t = 0; t < N_TERMS; t++) en_m[t] = 1'b0;
            phase_m    = '0;
            err_pend   = 1'b0;
            stall_prev = 1'b0;
        end else begin
            check("cfg_err", N_OUT'(bus.cfg_err), N_OUT'(err_pend));
            err_pend = 1'b0;
            if (stall_prev) begin
                check("hold_valid", N_OUT'(bus.out_valid), N_OUT'(1'b1));
                check("hold_data", bus.out_data, held);
            end
            stall_prev = bus.out_valid && !bus.out_ready;
            held       = bus.out_data;
            if (bus.out_valid && bus.out_ready) begin
                out_count++;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL spurious_out: got %h expected no result", bus.out_data);
                end else begin
                    check("out_data", bus.out_data, exp_q.pop_front());
                end
            end
            if (bus.in_valid && bus.in_ready) exp_q.push_back(model_z(bus.in_data));
            if (bus.cfg_valid && bus.cfg_ready) begin
                cfg_pulses++;
                case (bus.cfg_op)
                    CFG_WRITE: begin
                        if (int'(bus.cfg_term) < N_TERMS) begin
                            care_m[bus.cfg_term] = bus.cfg_care;
                            val_m[bus.cfg_term]  = bus.cfg_val;
                            or_m[bus.cfg_term]   = bus.cfg_or;
                            en_m[bus.cfg_term]   = 1'b1;
                        end else begin
                            err_pend = 1'b1;
                        end
                    end
                    CFG_CLEAR: for (int t = 0; t < N_TERMS; t++) en_m[t] = 1'b0;
                    CFG_PHASE: phase_m = bus.cfg_or;
                    default: ;
                endcase
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cfg(input cfg_op_e op, input logic [TW-1:0] term, input logic [N_IN-1:0] care,
                          input logic [N_IN-1:0] val, input logic [N_OUT-1:0] orr);
        bit got = 1'b0;
        int n = 0;
        bus.cfg_valid = 1'b1;
        bus.cfg_op    = op;
        bus.cfg_term  = term;
        bus.cfg_care  = care;
        bus.cfg_val   = val;
        bus.cfg_or    = orr;
        while (!got && n < 100) begin
            @(negedge clk);
            got = bus.cfg_ready;
            tick();
            n++;
        end
        bus.cfg_valid = 1'b0;
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL cfg_timeout: got no cfg_ready expected one within 100 cycles");
        end
    endtask

    task automatic send_vec(input logic [N_IN-1:0] x);
        bit got = 1'b0;
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = x;
        while (!got && n < 100) begin
            @(negedge clk);
            got = bus.in_ready;
            tick();
            n++;
        end
        bus.in_valid = 1'b0;
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL in_timeout: got no in_ready expected one within 100 cycles");
        end
    endtask

    task automatic eval(input logic [N_IN-1:0] x, output logic [N_OUT-1:0] z);
        bit got = 1'b0;
        int n = 0;
        z = '0;
        send_vec(x);
        while (!got && n < 100) begin
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) begin
                got = 1'b1;
                z = bus.out_data;
            end
            tick();
            n++;
        end
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL out_timeout: got no result expected one within 100 cycles");
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL idle_timeout: got %0d pending results expected 0", exp_q.size());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected one within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N_OUT-1:0] z;
        int acc_i, cycles, c0;
        bit got;

        bus.cfg_valid = 1'b0;
        bus.cfg_op    = CFG_WRITE;
        bus.cfg_term  = '0;
        bus.cfg_care  = '0;
        bus.cfg_val   = '0;
        bus.cfg_or    = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", N_OUT'(bus.out_valid), '0);
        check("rst_out_data", bus.out_data, '0);
        check("rst_cfg_err", N_OUT'(bus.cfg_err), '0);
        check("rst_cfg_ready", N_OUT'(bus.cfg_ready), '0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", N_OUT'(bus.in_ready), N_OUT'(1'b1));
        tick();

        // Two-cycle latency on an empty table.
        send_vec(8'hA5);
        @(negedge clk);
        check("lat_stage1", N_OUT'(bus.out_valid), '0);
        tick();
        @(negedge clk);
        check("lat_out_valid", N_OUT'(bus.out_valid), N_OUT'(1'b1));
        check("a5_empty", bus.out_data, '0);
        tick();

        do_cfg(CFG_PHASE, '0, '0, '0, {N_OUT{1'b1}});
        eval(8'h3C, z);
        check("phase_ones", z, {N_OUT{1'b1}});
        do_cfg(CFG_PHASE, '0, '0, '0, '0);

        do_cfg(CFG_WRITE, TW'(0), 8'h70, 8'h00, 63'h1);
        eval(8'h00, z);
        check("cube_x00", z, 63'h1);
        eval(8'h10, z);
        check("cube_x10", z, 63'h0);
        eval(8'h8F, z);
        check("cube_x8f", z, 63'h1);

        do_cfg(CFG_WRITE, TW'(1), 8'h03, 8'h01, 63'h21);
        eval(8'h01, z);
        check("overlap_x01", z, 63'h21);
        eval(8'h72, z);
        check("overlap_x72", z, 63'h0);

        // Back-to-back stream of 16 vectors.
        wait_idle();
        c0 = out_count;
        acc_i = 0;
        cycles = 0;
        bus.in_valid = 1'b1;
        while (acc_i < 16 && cycles < 100) begin
            bus.in_data = 8'(acc_i * 37 + 1);
            @(negedge clk);
            got = bus.in_ready;
            tick();
            if (got) acc_i++;
            cycles++;
        end
        bus.in_valid = 1'b0;
        check("stream_cycles", N_OUT'(cycles), N_OUT'(16));
        wait_idle();
        check("stream_count", N_OUT'(out_count - c0), N_OUT'(16));

        // Random table, random phase, randomized traffic with 50% backpressure.
        for (int k = 2; k < 8; k++)
            do_cfg(CFG_WRITE, TW'(k), 8'($urandom), 8'($urandom), 63'({$urandom, $urandom}));
        do_cfg(CFG_PHASE, '0, '0, '0, 63'({$urandom, $urandom}));
        c0 = out_count;
        acc_i = 0;
        cycles = 0;
        while (acc_i < 200 && cycles < 5000) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            if (!bus.in_valid) begin
                bus.in_valid = ($urandom_range(0, 3) != 0);
                bus.in_data  = 8'($urandom);
            end
            @(negedge clk);
            got = bus.in_valid && bus.in_ready;
            tick();
            if (got) begin
                acc_i++;
                bus.in_valid = 1'b0;
            end
            cycles++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        wait_idle();
        check("random_count", N_OUT'(out_count - c0), N_OUT'(200));
        do_cfg(CFG_PHASE, '0, '0, '0, '0);
        for (int k = 2; k < 8; k++) do_cfg(CFG_WRITE, TW'(k), '0, '0, '0);

        // Configuration request with two vectors in flight.
        c0 = cfg_pulses;
        send_vec(8'h01);
        send_vec(8'h02);
        bus.cfg_valid = 1'b1;
        bus.cfg_op    = CFG_WRITE;
        bus.cfg_term  = TW'(1);
        bus.cfg_care  = 8'h03;
        bus.cfg_val   = 8'h02;
        bus.cfg_or    = 63'h40;
        @(negedge clk);
        check("cfg_blocks_in", N_OUT'(bus.in_ready), '0);
        tick();
        do_cfg(CFG_WRITE, TW'(1), 8'h03, 8'h02, 63'h40);
        check("cfg_one_pulse", N_OUT'(cfg_pulses - c0), N_OUT'(1));
        wait_idle();
        eval(8'h02, z);
        check("new_table_x02", z, 63'h41);

        // Out-of-range write: error pulse, table untouched.
        do_cfg(CFG_WRITE, TW'(N_TERMS), 8'hFF, 8'h02, {N_OUT{1'b1}});
        @(negedge clk);
        check("cfg_err_pulse", N_OUT'(bus.cfg_err), N_OUT'(1'b1));
        tick();
        eval(8'h02, z);
        check("bad_write_noop", z, 63'h41);

        do_cfg(CFG_CLEAR, '0, '0, '0, '0);
        do_cfg(CFG_PHASE, '0, '0, '0, 63'h5555_AAAA_0F0F_1234);
        eval(8'h02, z);
        check("clear_x02", z, 63'h5555_AAAA_0F0F_1234);
        eval(8'h00, z);
        check("clear_x00", z, 63'h5555_AAAA_0F0F_1234);

        // Reset while vectors are in flight and stalled.
        do_cfg(CFG_WRITE, TW'(3), 8'h00, 8'h00, 63'h7);
        bus.out_ready = 1'b0;
        send_vec(8'h11);
        send_vec(8'h22);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", N_OUT'(bus.out_valid), '0);
        check("midrst_out_data", bus.out_data, '0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        eval(8'h00, z);
        check("post_reset_empty", z, '0);
        wait_idle();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
